scsi_slave_sequencer: RTL and testbench



---
 rtl/scsi_pkg.sv | 34 +++
 rtl/scsi_slave_sequencer_if.sv | 29 ++
 rtl/scsi_slave_sequencer_sync2.sv | 22 ++
 rtl/scsi_slave_sequencer.sv | 124 ++++++++++++
 tb/tb_scsi_slave_sequencer.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/scsi_pkg.sv
// Shared SCSI-region definitions: FSM state codes, 53C710 SIZ encodings and
// the Zorro DS_n lane decode (also used by the DMA master checks).
package scsi_pkg;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SETUP    = 3'd1;
    localparam logic [2:0] S_STROBE   = 3'd2;
    localparam logic [2:0] S_WAIT_ACK = 3'd3;
    localparam logic [2:0] S_ACK      = 3'd4;
    localparam logic [2:0] S_TIMEOUT  = 3'd5;
    localparam logic [2:0] S_RECOVER  = 3'd6;

    localparam logic [1:0] SIZ_LONG = 2'b00;
    localparam logic [1:0] SIZ_BYTE = 2'b01;
    localparam logic [1:0] SIZ_WORD = 2'b10;

    // Returns {SIZ, A[1:0]}; DS_n[3] is byte offset 0. Unsupported patterns fall back to long.
    function automatic logic [3:0] lane_decode(input logic [3:0] ds_n);
        logic [3:0] r;
        r = {SIZ_LONG, 2'b00};
        case (ds_n)
            4'b0000: r = {SIZ_LONG, 2'b00};
            4'b0011: r = {SIZ_WORD, 2'b00};
            4'b1100: r = {SIZ_WORD, 2'b10};
            4'b0111: r = {SIZ_BYTE, 2'b00};
            4'b1011: r = {SIZ_BYTE, 2'b01};
            4'b1101: r = {SIZ_BYTE, 2'b10};
            4'b1110: r = {SIZ_BYTE, 2'b11};
            default: r = {SIZ_LONG, 2'b00};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/scsi_slave_sequencer_if.sv
// Zorro-slave-SM / 53C710 signal bundle for the SCSI slave sequencer.
// The sequencer uses the slave modport; the Zorro side (or a bench) uses master.
interface scsi_slave_sequencer_if;
    logic       scsi_cycle;
    logic       cycle_active;
    logic       READ;
    logic [3:0] DS_n;
    logic       SLACK_n;
    logic       SCSI_AS_n;
    logic       SCSI_DS_n;
    logic       SCSI_SREG_n;
    logic [1:0] SCSI_SIZ;
    logic [1:0] SCSI_A;
    logic       scsi_dtack;
    logic       scsi_berr;
    logic       busy;

    modport slave (
        input  scsi_cycle, cycle_active, READ, DS_n, SLACK_n,
        output SCSI_AS_n, SCSI_DS_n, SCSI_SREG_n, SCSI_SIZ, SCSI_A,
               scsi_dtack, scsi_berr, busy
    );

    modport master (
        output scsi_cycle, cycle_active, READ, DS_n, SLACK_n,
        input  SCSI_AS_n, SCSI_DS_n, SCSI_SREG_n, SCSI_SIZ, SCSI_A,
               scsi_dtack, scsi_berr, busy
    );
endinterface

// File: rtl/scsi_slave_sequencer_sync2.sv
// Two-flop synchroniser; output is d delayed by two CLK edges.
// Reset value is configurable so an active-low input resets to its negated level.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic CLK,
    input  logic RESET,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/scsi_slave_sequencer.sv
// Drives 53C710 AS/DS/SREG and SIZ/A for Zorro slave cycles to the SCSI window,
// returns scsi_dtack on SLACK_n, aborts with scsi_berr on timeout, enforces recovery.
module scsi_slave_sequencer
    import scsi_pkg::*;
#(
    parameter int TIMEOUT_CYCLES  = 255,
    parameter int RECOVERY_CYCLES = 2,
    parameter int CNT_W           = 8
) (
    input  logic                        CLK,
    input  logic                        RESET,
    scsi_slave_sequencer_if.slave       bus
);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] REC_LAST = CNT_W'(RECOVERY_CYCLES - 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             rd_q;
    logic [1:0]       siz_q;
    logic [1:0]       a_q;
    logic             as_n_q;
    logic             ds_n_q;
    logic             sreg_n_q;
    logic             dtack_q;
    logic             berr_q;
    logic             slack_s;
    logic             enter_rec;

    sync2 #(.RST_VAL(1'b1)) u_slack_sync (
        .CLK   (CLK),
        .RESET (RESET),
        .d     (bus.SLACK_n),
        .q     (slack_s)
    );

    // Master ending the cycle beats any acknowledge seen in the same clock.
    assign enter_rec = !bus.cycle_active &&
                       (state == S_SETUP || state == S_STROBE || state == S_WAIT_ACK ||
                        state == S_ACK   || state == S_TIMEOUT);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= S_IDLE;
            cnt      <= '0;
            rd_q     <= 1'b0;
            siz_q    <= SIZ_LONG;
            a_q      <= 2'b00;
            as_n_q   <= 1'b1;
            ds_n_q   <= 1'b1;
            sreg_n_q <= 1'b1;
            dtack_q  <= 1'b0;
            berr_q   <= 1'b0;
        end else begin
            berr_q <= 1'b0;
            if (enter_rec) begin
                state    <= S_RECOVER;
                cnt      <= '0;
                as_n_q   <= 1'b1;
                ds_n_q   <= 1'b1;
                sreg_n_q <= 1'b1;
                dtack_q  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.scsi_cycle && bus.cycle_active && bus.DS_n != 4'b1111) begin
                            state          <= S_SETUP;
                            rd_q           <= bus.READ;
                            {siz_q, a_q}   <= lane_decode(bus.DS_n);
                            sreg_n_q       <= 1'b0;
                        end
                    end
                    S_SETUP: begin
                        // Hold here while a previous cycle's SLACK_n is still low.
                        if (slack_s) begin
                            state  <= S_STROBE;
                            as_n_q <= 1'b0;
                            ds_n_q <= !rd_q;
                        end
                    end
                    S_STROBE: begin
                        if (ds_n_q) begin
                            ds_n_q <= 1'b0;
                        end else begin
                            state <= S_WAIT_ACK;
                            cnt   <= '0;
                        end
                    end
                    S_WAIT_ACK: begin
                        if (!slack_s) begin
                            state   <= S_ACK;
                            dtack_q <= 1'b1;
                        end else if (cnt == TMO_LAST) begin
                            state    <= S_TIMEOUT;
                            as_n_q   <= 1'b1;
                            ds_n_q   <= 1'b1;
                            sreg_n_q <= 1'b1;
                            berr_q   <= 1'b1;
                        end else if (cnt != '1) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_ACK, S_TIMEOUT: begin
                    end
                    S_RECOVER: begin
                        if (cnt >= REC_LAST) state <= S_IDLE;
                        else                 cnt   <= cnt + 1'b1;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.SCSI_AS_n   = as_n_q;
    assign bus.SCSI_DS_n   = ds_n_q;
    assign bus.SCSI_SREG_n = sreg_n_q;
    assign bus.SCSI_SIZ    = siz_q;
    assign bus.SCSI_A      = a_q;
    assign bus.scsi_dtack  = dtack_q;
    assign bus.scsi_berr   = berr_q;
    assign bus.busy        = (state != S_IDLE);

endmodule

// File: tb/tb_scsi_slave_sequencer.sv
// Directed bench for scsi_slave_sequencer: lane-decode table plus hand-written
// sequences for read/write timing, timeout, abort, stale SLACK_n, recovery and reset.
module tb_scsi_slave_sequencer;
    import scsi_pkg::*;

    localparam int TMO = 16;
    localparam int REC = 2;

    logic CLK = 1'b0;
    logic RESET;
    int   n_checks = 0;
    int   n_fail   = 0;

    scsi_slave_sequencer_if bus();

    scsi_slave_sequencer #(
        .TIMEOUT_CYCLES  (TMO),
        .RECOVERY_CYCLES (REC),
        .CNT_W           (8)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #20 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [3:0] ds;
        logic       rd;
        logic       busy;
        logic [1:0] siz;
        logic [1:0] a;
    } vec_t;

    vec_t vec[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs;
        bus.scsi_cycle   = 1'b0;
        bus.cycle_active = 1'b0;
        bus.READ         = 1'b0;
        bus.DS_n         = 4'b1111;
        bus.SLACK_n      = 1'b1;
    endtask

    task automatic start_cycle(input logic [3:0] ds, input logic rd);
        bus.scsi_cycle   = 1'b1;
        bus.cycle_active = 1'b1;
        bus.READ         = rd;
        bus.DS_n         = ds;
    endtask

    // Steps until AS_n asserts; n counts edges including the asserting one.
    task automatic wait_as(output int n);
        int glitch;
        n = 0;
        glitch = 0;
        do begin
            step();
            n++;
            if (bus.SCSI_AS_n === 1'b1 && bus.SCSI_DS_n !== 1'b1) glitch++;
        end while (bus.SCSI_AS_n !== 1'b0 && n < 20);
        chk("as_assert", {31'd0, bus.SCSI_AS_n}, 32'd0);
        chk("ds_glitch", glitch, 0);
    endtask

    // Acknowledge, wait for dtack, end the cycle; returns right after the RECOVER edge.
    task automatic ack_and_end;
        int n;
        bus.SLACK_n = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (bus.scsi_dtack !== 1'b1 && n < 20);
        chk("dtack_rise", {31'd0, bus.scsi_dtack}, 32'd1);
        idle_inputs();
        step();
        chk("end_dtack", {31'd0, bus.scsi_dtack}, 32'd0);
        chk("end_as", {31'd0, bus.SCSI_AS_n}, 32'd1);
        chk("end_busy", {31'd0, bus.busy}, 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_as"},    {31'd0, bus.SCSI_AS_n},   32'd1);
        chk({tag, "_ds"},    {31'd0, bus.SCSI_DS_n},   32'd1);
        chk({tag, "_sreg"},  {31'd0, bus.SCSI_SREG_n}, 32'd1);
        chk({tag, "_siz"},   {30'd0, bus.SCSI_SIZ},    32'd0);
        chk({tag, "_a"},     {30'd0, bus.SCSI_A},      32'd0);
        chk({tag, "_dtack"}, {31'd0, bus.scsi_dtack},  32'd0);
        chk({tag, "_berr"},  {31'd0, bus.scsi_berr},   32'd0);
        chk({tag, "_busy"},  {31'd0, bus.busy},        32'd0);
    endtask

    initial begin
        int n, neg_at, berr_cnt, dtack_cnt, as_low;

        vec[0] = '{4'b0000, 1'b1, 1'b1, SIZ_LONG, 2'b00};
        vec[1] = '{4'b0011, 1'b1, 1'b1, SIZ_WORD, 2'b00};
        vec[2] = '{4'b1100, 1'b0, 1'b1, SIZ_WORD, 2'b10};
        vec[3] = '{4'b0111, 1'b1, 1'b1, SIZ_BYTE, 2'b00};
        vec[4] = '{4'b1011, 1'b0, 1'b1, SIZ_BYTE, 2'b01};
        vec[5] = '{4'b1101, 1'b1, 1'b1, SIZ_BYTE, 2'b10};
        vec[6] = '{4'b1110, 1'b0, 1'b1, SIZ_BYTE, 2'b11};
        vec[7] = '{4'b1010, 1'b1, 1'b1, SIZ_LONG, 2'b00};
        vec[8] = '{4'b0001, 1'b0, 1'b1, SIZ_LONG, 2'b00};
        vec[9] = '{4'b1111, 1'b1, 1'b0, SIZ_LONG, 2'b00};

        RESET = 1'b1;
        idle_inputs();
        repeat (3) step();
        chk_reset_vals("rst");
        RESET = 1'b0;
        step();

        // Lane decode table: check SETUP outputs, then abort back to IDLE.
        for (int i = 0; i < 10; i++) begin
            start_cycle(vec[i].ds, vec[i].rd);
            step();
            chk("tbl_busy", {31'd0, bus.busy}, {31'd0, vec[i].busy});
            chk("tbl_sreg", {31'd0, bus.SCSI_SREG_n}, {31'd0, !vec[i].busy});
            chk("tbl_as",   {31'd0, bus.SCSI_AS_n}, 32'd1);
            if (vec[i].busy) begin
                chk("tbl_siz", {30'd0, bus.SCSI_SIZ}, {30'd0, vec[i].siz});
                chk("tbl_a",   {30'd0, bus.SCSI_A},   {30'd0, vec[i].a});
            end
            idle_inputs();
            repeat (3) step();
            chk("tbl_idle", {31'd0, bus.busy}, 32'd0);
        end

        // Long read: AS/DS together, dtack three edges after SLACK_n falls.
        start_cycle(4'b0000, 1'b1);
        wait_as(n);
        chk("rd_as_lat", n, 2);
        chk("rd_ds_with_as", {31'd0, bus.SCSI_DS_n}, 32'd0);
        chk("rd_siz", {30'd0, bus.SCSI_SIZ}, 32'd0);
        repeat (3) step();
        bus.SLACK_n = 1'b0;
        step();
        step();
        chk("rd_dtack_early", {31'd0, bus.scsi_dtack}, 32'd0);
        step();
        chk("rd_dtack_rise", {31'd0, bus.scsi_dtack}, 32'd1);
        repeat (2) step();
        chk("rd_dtack_hold", {31'd0, bus.scsi_dtack}, 32'd1);
        idle_inputs();
        step();
        chk("rd_dtack_drop", {31'd0, bus.scsi_dtack}, 32'd0);
        chk("rd_as_drop", {31'd0, bus.SCSI_AS_n}, 32'd1);
        chk("rd_recover", {31'd0, bus.busy}, 32'd1);
        repeat (2) step();
        chk("rd_idle", {31'd0, bus.busy}, 32'd0);

        // Byte write: DS_n lags AS_n by one cycle; next cycle held off by recovery.
        start_cycle(4'b1101, 1'b0);
        wait_as(n);
        chk("wr_as_lat", n, 2);
        chk("wr_ds_late", {31'd0, bus.SCSI_DS_n}, 32'd1);
        chk("wr_siz", {30'd0, bus.SCSI_SIZ}, {30'd0, SIZ_BYTE});
        chk("wr_a", {30'd0, bus.SCSI_A}, 32'd2);
        step();
        chk("wr_ds_assert", {31'd0, bus.SCSI_DS_n}, 32'd0);
        chk("wr_as_still", {31'd0, bus.SCSI_AS_n}, 32'd0);
        ack_and_end();
        start_cycle(4'b0000, 1'b1);
        wait_as(n);
        chk("wr_recovery_gap", n, REC + 2);
        ack_and_end();
        repeat (2) step();

        // Back-to-back word reads, second requested during RECOVER.
        start_cycle(4'b0011, 1'b1);
        wait_as(n);
        chk("w1_siz", {30'd0, bus.SCSI_SIZ}, {30'd0, SIZ_WORD});
        chk("w1_a", {30'd0, bus.SCSI_A}, 32'd0);
        ack_and_end();
        start_cycle(4'b1100, 1'b1);
        wait_as(n);
        chk("w2_gap", n, REC + 2);
        chk("w2_siz", {30'd0, bus.SCSI_SIZ}, {30'd0, SIZ_WORD});
        chk("w2_a", {30'd0, bus.SCSI_A}, 32'd2);
        ack_and_end();
        repeat (2) step();
        chk("w2_idle", {31'd0, bus.busy}, 32'd0);

        // Acknowledge timeout with no SLACK_n.
        start_cycle(4'b0000, 1'b1);
        wait_as(n);
        step();
        neg_at = -1;
        berr_cnt = 0;
        dtack_cnt = 0;
        for (int i = 1; i <= 24; i++) begin
            step();
            if (bus.SCSI_AS_n === 1'b1 && neg_at < 0) neg_at = i;
            if (bus.scsi_berr === 1'b1) berr_cnt++;
            if (bus.scsi_dtack === 1'b1) dtack_cnt++;
        end
        chk("tmo_neg_at", neg_at, TMO);
        chk("tmo_berr_pulses", berr_cnt, 1);
        chk("tmo_no_dtack", dtack_cnt, 0);
        chk("tmo_hold_busy", {31'd0, bus.busy}, 32'd1);
        idle_inputs();
        repeat (3) step();
        chk("tmo_idle", {31'd0, bus.busy}, 32'd0);

        // Abort in STROBE while SLACK_n falls the same cycle.
        start_cycle(4'b0000, 1'b1);
        step();
        step();
        chk("ab_as", {31'd0, bus.SCSI_AS_n}, 32'd0);
        bus.scsi_cycle   = 1'b0;
        bus.cycle_active = 1'b0;
        bus.DS_n         = 4'b1111;
        bus.SLACK_n      = 1'b0;
        step();
        chk("ab_as_neg", {31'd0, bus.SCSI_AS_n}, 32'd1);
        chk("ab_recover", {31'd0, bus.busy}, 32'd1);
        berr_cnt = 0;
        dtack_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.scsi_berr === 1'b1) berr_cnt++;
            if (bus.scsi_dtack === 1'b1) dtack_cnt++;
            step();
        end
        chk("ab_no_berr", berr_cnt, 0);
        chk("ab_no_dtack", dtack_cnt, 0);
        chk("ab_idle", {31'd0, bus.busy}, 32'd0);

        // Stale SLACK_n still low: SETUP must not advance until it releases.
        start_cycle(4'b0111, 1'b1);
        step();
        as_low = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.SCSI_AS_n !== 1'b1) as_low++;
        end
        chk("stale_hold", as_low, 0);
        chk("stale_busy", {31'd0, bus.busy}, 32'd1);
        bus.SLACK_n = 1'b1;
        wait_as(n);
        chk("stale_release", n, 3);
        chk("stale_siz", {30'd0, bus.SCSI_SIZ}, {30'd0, SIZ_BYTE});
        idle_inputs();
        repeat (3) step();

        // Reset in WAIT_ACK, then a normal byte write.
        start_cycle(4'b1100, 1'b1);
        wait_as(n);
        repeat (2) step();
        RESET = 1'b1;
        idle_inputs();
        step();
        chk_reset_vals("mrst");
        RESET = 1'b0;
        step();
        start_cycle(4'b1011, 1'b0);
        wait_as(n);
        chk("post_rst_lat", n, 2);
        chk("post_rst_siz", {30'd0, bus.SCSI_SIZ}, {30'd0, SIZ_BYTE});
        chk("post_rst_a", {30'd0, bus.SCSI_A}, 32'd1);
        step();
        chk("post_rst_ds", {31'd0, bus.SCSI_DS_n}, 32'd0);
        ack_and_end();
        repeat (2) step();
        chk("post_rst_idle", {31'd0, bus.busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
